mm_timer_bank: RTL

- Parametrised, multi-channel successor to the single memory-mapped Timer on the processor data bus.
- NUM_CH independent millisecond-style counters share one prescaler. Each channel has a limit, auto-reload, a sticky ready flag and an overrun flag, plus a combined interrupt output.
- Sits on the wired-OR data bus beside DataMemory, with the same abus/dbus_in/dbus_out/wren contract. It drives zero when not addressed.

---
 rtl/mm_timer_pkg.sv | 23 ++
 rtl/mm_timer_chan.sv | 112 +++++++++++
 rtl/mm_timer_bank.sv | 115 +++++++++++
 3 files changed

// File: rtl/mm_timer_pkg.sv
// Shared constants for the memory-mapped timer bank: register offsets, CTL/STAT bit
// positions and the per-channel address stride.
package mm_timer_pkg;

  // Word offsets inside a channel block (abus[3:2])
  localparam logic [1:0] OFF_CNT  = 2'd0;
  localparam logic [1:0] OFF_LIM  = 2'd1;
  localparam logic [1:0] OFF_CTL  = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  // CTL bits
  localparam int unsigned CTL_EN = 0;
  localparam int unsigned CTL_AR = 1;
  localparam int unsigned CTL_IE = 2;

  // STAT bits
  localparam int unsigned STAT_RDY = 0;
  localparam int unsigned STAT_OVR = 1;

  // Byte distance between consecutive channel blocks
  localparam int unsigned CH_STRIDE = 16;

endpackage

// File: rtl/mm_timer_chan.sv
// One timer channel: CNT/LIM/CTL/STAT registers, tick-driven counting with optional
// auto-reload, sticky ready/overrun flags and a per-channel interrupt request.
module mm_timer_chan
  import mm_timer_pkg::*;
#(
  parameter int unsigned DBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [1:0]       off_i,
  input  logic [DBITS-1:0] wdata_i,
  output logic [DBITS-1:0] rdata_o,
  output logic             irq_o
);

  logic [DBITS-1:0] cnt_q, cnt_d;
  logic [DBITS-1:0] lim_q, lim_d;
  logic             en_q, en_d;
  logic             ar_q, ar_d;
  logic             ie_q, ie_d;
  logic             rdy_q, rdy_d;
  logic             ovr_q, ovr_d;
  logic             hit;

  // Next state: tick effects from pre-write values, then CPU writes override CNT/LIM/CTL;
  // a hardware set of STAT beats a same-cycle write-1-to-clear.
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    en_d  = en_q;
    ar_d  = ar_q;
    ie_d  = ie_q;
    rdy_d = rdy_q;
    ovr_d = ovr_q;
    hit   = tick_i && en_q && (cnt_q == lim_q);

    if (tick_i && en_q) begin
      if (cnt_q == lim_q) begin
        cnt_d = '0;
        if (!ar_q) en_d = 1'b0;
      end else begin
        cnt_d = cnt_q + DBITS'(1);
      end
    end

    if (we_i && (off_i == OFF_STAT)) begin
      if (wdata_i[STAT_RDY]) rdy_d = 1'b0;
      if (wdata_i[STAT_OVR]) ovr_d = 1'b0;
    end
    if (hit) begin
      rdy_d = 1'b1;
      if (rdy_q) ovr_d = 1'b1;
    end

    if (we_i) begin
      unique case (off_i)
        OFF_CNT: cnt_d = wdata_i;
        OFF_LIM: lim_d = wdata_i;
        OFF_CTL: begin
          en_d = wdata_i[CTL_EN];
          ar_d = wdata_i[CTL_AR];
          ie_d = wdata_i[CTL_IE];
        end
        default: ;
      endcase
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
      en_q  <= 1'b0;
      ar_q  <= 1'b0;
      ie_q  <= 1'b0;
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      en_q  <= en_d;
      ar_q  <= ar_d;
      ie_q  <= ie_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
    end
  end

  // Combinational register read; unused CTL/STAT bits read as zero
  always_comb begin
    rdata_o = '0;
    unique case (off_i)
      OFF_CNT: rdata_o = cnt_q;
      OFF_LIM: rdata_o = lim_q;
      OFF_CTL: begin
        rdata_o[CTL_EN] = en_q;
        rdata_o[CTL_AR] = ar_q;
        rdata_o[CTL_IE] = ie_q;
      end
      OFF_STAT: begin
        rdata_o[STAT_RDY] = rdy_q;
        rdata_o[STAT_OVR] = ovr_q;
      end
    endcase
  end

  assign irq_o = rdy_q & ie_q;

endmodule

// File: rtl/mm_timer_bank.sv
// Multi-channel memory-mapped timer on the wired-OR data bus. Holds the shared prescaler,
// address decode and read OR-mux; channels live in mm_timer_chan.
// Optional macro MM_TIMER_PRESCALE_REG_EN adds a writable PDIV (terminal count) register
// at BASE_ADDR + 16*NUM_CH; without it the terminal count is fixed at CLK_DIV-1.
module mm_timer_bank
  import mm_timer_pkg::*;
#(
  parameter int unsigned      DBITS     = 32,
  parameter int unsigned      NUM_CH    = 4,
  parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000020,
  parameter int unsigned      CLK_DIV   = 50000,
  parameter int unsigned      PDIV_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBITS-1:0] abus,
  input  logic [DBITS-1:0] dbus_in,
  input  logic             wren,
  output logic [DBITS-1:0] dbus_out,
  output logic             irq,
  output logic             tick
);

  localparam logic [PDIV_BITS-1:0] TERM_RST = PDIV_BITS'(CLK_DIV - 1);

  logic [DBITS-1:0]     rel;
  logic [DBITS-1:0]     blk;
  logic [1:0]           off;
  logic                 word_ok;
  logic [NUM_CH-1:0]    chan_sel;
  logic [NUM_CH-1:0]    chan_irq;
  logic [DBITS-1:0]     chan_rdata [NUM_CH];

  logic [PDIV_BITS-1:0] pdiv_q, pdiv_d;
  logic                 tick_q, tick_d;
  logic [PDIV_BITS-1:0] term;
  logic [PDIV_BITS-1:0] term_nxt;

  // Address decode relative to the bank base; wrap-around keeps below-base addresses unmapped
  assign rel     = abus - BASE_ADDR;
  assign blk     = rel / DBITS'(CH_STRIDE);
  assign off     = rel[3:2];
  assign word_ok = (abus[1:0] == 2'b00);

`ifdef MM_TIMER_PRESCALE_REG_EN
  logic                 pdiv_sel;
  logic [PDIV_BITS-1:0] term_q;

  assign pdiv_sel = word_ok && (blk == DBITS'(NUM_CH)) && (off == 2'd0);
  assign term     = term_q;
  assign term_nxt = (wren && pdiv_sel) ? dbus_in[PDIV_BITS-1:0] : term_q;

  // Terminal-count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) term_q <= TERM_RST;
    else     term_q <= term_nxt;
  end
`else
  assign term     = TERM_RST;
  assign term_nxt = TERM_RST;
`endif

  // Prescaler next state; tick is registered so it is high exactly while pdiv == term
  always_comb begin
    pdiv_d = (pdiv_q == term) ? '0 : pdiv_q + PDIV_BITS'(1);
`ifdef MM_TIMER_PRESCALE_REG_EN
    if (wren && pdiv_sel) pdiv_d = '0;
`endif
    tick_d = (pdiv_d == term_nxt);
  end

  // Prescaler registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdiv_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pdiv_q <= pdiv_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    assign chan_sel[c] = word_ok && (blk == DBITS'(c));

    mm_timer_chan #(
      .DBITS(DBITS)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick_q),
      .we_i   (wren && chan_sel[c]),
      .off_i  (off),
      .wdata_i(dbus_in),
      .rdata_o(chan_rdata[c]),
      .irq_o  (chan_irq[c])
    );
  end

  // Read OR-mux; drives zero whenever nothing in the bank is addressed
  always_comb begin
    dbus_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chan_sel[c]) dbus_out = dbus_out | chan_rdata[c];
    end
`ifdef MM_TIMER_PRESCALE_REG_EN
    if (pdiv_sel) dbus_out = dbus_out | DBITS'(term_q);
`endif
  end

  assign irq = |chan_irq;

endmodule
